mult_div_unit: RTL and testbench

Iterative multiply/divide responder for the execution stage of the dual-issue pipeline. It accepts a one-cycle start request with two operands and a 2-bit op, computes for a fixed `width` cycles, and holds the stage stalled through `multStall_E` while it works. It publishes the 64-bit result on `hi_E`/`lo_E`. The falling edge of `multStall_E` coincides with a one-cycle `done` pulse, which the top level uses to capture the result into its HI/LO holding registers.

---
 rtl/mult_div_unit_if.sv | 37 +++
 rtl/mult_div_unit.sv | 219 +++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
//   Request/response bundle between the execute stage and the iterative
//   multiply/divide unit.
//   master : execute stage (drives start/op/operands/flush, sees stall/done/result)
//   slave  : mult_div_unit
//   Signals:
//     start_E      request pulse
//     op_E[1:0]    00 multu, 01 mult, 10 divu, 11 div
//     srcA_E       multiplicand / dividend
//     srcB_E       multiplier / divisor
//     flush_E      abort in-flight or requested operation
//     multStall_E  busy / stall to hazard unit
//     done         one-cycle result-valid pulse
//     lo_E, hi_E   product low/high, or quotient/remainder
interface mult_div_unit_if #(
  parameter int width = 32
);
  logic             start_E;
  logic [1:0]       op_E;
  logic [width-1:0] srcA_E;
  logic [width-1:0] srcB_E;
  logic             flush_E;
  logic             multStall_E;
  logic             done;
  logic [width-1:0] lo_E;
  logic [width-1:0] hi_E;

  modport master (
    output start_E, op_E, srcA_E, srcB_E, flush_E,
    input  multStall_E, done, lo_E, hi_E
  );

  modport slave (
    input  start_E, op_E, srcA_E, srcB_E, flush_E,
    output multStall_E, done, lo_E, hi_E
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative multiply/divide responder. A start accepted outside RUN spends
//   exactly `width` cycles in RUN (one multiplier/quotient bit per cycle), then
//   one cycle in DONE where `done` pulses. Results on hi_E/lo_E change only on
//   the RUN->DONE edge.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset, clears all state
//     bus    mult_div_unit_if.slave (start/op/operands/flush in,
//            stall/done/hi/lo out)
module mult_div_unit #(
  parameter int width = 32
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam int CNT_W = (width > 1) ? $clog2(width) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*width-1:0] acc_q, acc_d;
  logic [width-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dvz_q, dvz_d;
  logic [width-1:0]   orig_a_q, orig_a_d;
  logic [width-1:0]   hi_q, hi_d;
  logic [width-1:0]   lo_q, lo_d;

  logic               accept;
  logic               last_iter;
  logic               a_neg, b_neg;
  logic [width-1:0]   a_abs, b_abs;
  logic               stall;
  logic               done_o;

  // Conditional two's-complement negation of a single word.
  function automatic logic signed [width-1:0] cond_neg_w(
    input logic signed [width-1:0] v,
    input logic                    neg
  );
    return neg ? -v : v;
  endfunction

  // Conditional two's-complement negation over the full double word.
  function automatic logic signed [2*width-1:0] cond_neg_2w(
    input logic signed [2*width-1:0] v,
    input logic                      neg
  );
    return neg ? -v : v;
  endfunction

  // Shift-add: accumulator is {partial_product, remaining_multiplier}.
  // The multiplier LSB selects an add; the carry shifts into the top bit.
  function automatic logic [2*width-1:0] mul_step(
    input logic [2*width-1:0] acc,
    input logic [width-1:0]   mcand
  );
    logic [width:0] sum;
    sum = {1'b0, acc[2*width-1:width]} + (acc[0] ? {1'b0, mcand} : '0);
    return {sum, acc[width-1:1]};
  endfunction

  // Restoring division: accumulator is {remainder, dividend/quotient}.
  // The shifted remainder is width+1 bits; if its top bit is set it must
  // exceed any divisor, and the true difference then fits in width bits,
  // so a width-bit subtract is exact whenever the trial succeeds.
  function automatic logic [2*width-1:0] div_step(
    input logic [2*width-1:0] acc,
    input logic [width-1:0]   dvsr
  );
    logic [width-1:0] rem_lo;
    logic [width-1:0] diff;
    logic             fits;
    rem_lo = {acc[2*width-2:width], acc[width-1]};
    fits   = acc[2*width-1] | (rem_lo >= dvsr);
    diff   = rem_lo - dvsr;
    return fits ? {diff, acc[width-2:0], 1'b1}
                : {rem_lo, acc[width-2:0], 1'b0};
  endfunction

  // Final sign fix-up. Divide by zero bypasses the datapath result and
  // reports {original dividend, all ones} regardless of signedness.
  function automatic logic [2*width-1:0] fix_up(
    input logic [2*width-1:0] raw,
    input logic               div_op,
    input logic               neg_res,
    input logic               neg_rem,
    input logic               dvz,
    input logic [width-1:0]   orig_a
  );
    if (div_op) begin
      if (dvz) return {orig_a, {width{1'b1}}};
      return {cond_neg_w(raw[2*width-1:width], neg_rem),
              cond_neg_w(raw[width-1:0], neg_res)};
    end
    return cond_neg_2w(raw, neg_res);
  endfunction

  assign accept    = (state_q != S_RUN) & bus.start_E & ~bus.flush_E;
  assign last_iter = (cnt_q == CNT_W'(width - 1));

  // Magnitudes of the operands; the most-negative value maps onto itself,
  // which is the correct unsigned magnitude.
  assign a_neg = bus.op_E[0] & bus.srcA_E[width-1];
  assign b_neg = bus.op_E[0] & bus.srcB_E[width-1];
  assign a_abs = a_neg ? (-bus.srcA_E) : bus.srcA_E;
  assign b_abs = b_neg ? (-bus.srcB_E) : bus.srcB_E;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN: begin
        if (bus.flush_E)    state_d = S_IDLE;
        else if (last_iter) state_d = S_DONE;
      end
      S_DONE:  state_d = accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; stall is combinational from start so the issuing
  // instruction stalls in its own cycle.
  always_comb begin
    stall  = (state_q == S_RUN) | accept;
    done_o = (state_q == S_DONE);
  end

  assign bus.multStall_E = stall;
  assign bus.done        = done_o;
  assign bus.hi_E        = hi_q;
  assign bus.lo_E        = lo_q;

  // Datapath next-value logic
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dvz_d     = dvz_q;
    orig_a_d  = orig_a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (accept) begin
      cnt_d     = '0;
      is_div_d  = bus.op_E[1];
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      dvz_d     = bus.op_E[1] & (bus.srcB_E == '0);
      orig_a_d  = bus.srcA_E;
      if (bus.op_E[1]) begin
        acc_d  = {{width{1'b0}}, a_abs};
        opnd_d = b_abs;
      end else begin
        acc_d  = {{width{1'b0}}, b_abs};
        opnd_d = a_abs;
      end
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = is_div_q ? div_step(acc_q, opnd_q) : mul_step(acc_q, opnd_q);
      if (last_iter && !bus.flush_E) begin
        {hi_d, lo_d} = fix_up(acc_d, is_div_q, neg_res_q, neg_rem_q,
                              dvz_q, orig_a_q);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvz_q     <= 1'b0;
      orig_a_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dvz_q     <= dvz_d;
      orig_a_q  <= orig_a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed bench for mult_div_unit (width = 32). A cycle-level reference
//   model built from plain arithmetic predicts stall/done/hi/lo every cycle;
//   directed sequences add hand-computed literal expectations.
module tb_mult_div_unit;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   chk_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  mult_div_unit_if #(.width(W)) bus ();

  mult_div_unit #(.width(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0: return ua * ub;
      2'd1: return sa * sb;
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  // Cycle-level model: remaining busy cycles, pending result, published result.
  int          m_run;
  logic        m_done;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run  <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_run > 0) begin
        if (bus.flush_E) begin
          m_run <= 0;
        end else begin
          m_run <= m_run - 1;
          if (m_run == 1) begin
            m_done <= 1'b1;
            m_hi   <= p_hi;
            m_lo   <= p_lo;
          end
        end
      end else if (bus.start_E && !bus.flush_E) begin
        m_run <= W;
        {p_hi, p_lo} <= ref_result(bus.op_E, bus.srcA_E, bus.srcB_E);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check32("cyc_stall", 32'(bus.multStall_E),
              32'((m_run > 0) || (bus.start_E && !bus.flush_E)));
      check32("cyc_done", 32'(bus.done), 32'(m_done));
      check32("cyc_hi", bus.hi_E, m_hi);
      check32("cyc_lo", bus.lo_E, m_lo);
    end
  end

  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n_stall;
    bit got;
    @(posedge clk); #1;
    bus.start_E = 1'b1;
    bus.op_E    = op;
    bus.srcA_E  = a;
    bus.srcB_E  = b;
    n_stall = 0;
    got     = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.multStall_E) n_stall++;
      if (bus.done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        bus.start_E = 1'b0;
      end
    end
    bus.start_E = 1'b0;
    check32({name, "_done_seen"}, 32'(got), 32'd1);
    check32({name, "_stall_cycles"}, 32'(n_stall), 32'd33);
    check32({name, "_hi"}, bus.hi_E, exp_hi);
    check32({name, "_lo"}, bus.lo_E, exp_lo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int lat;
    bit got;
    bus.start_E = 1'b0;
    bus.flush_E = 1'b0;
    bus.op_E    = 2'd0;
    bus.srcA_E  = '0;
    bus.srcB_E  = '0;

    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check32("rst_stall", 32'(bus.multStall_E), 32'd0);
    check32("rst_done", 32'(bus.done), 32'd0);
    check32("rst_hi", bus.hi_E, 32'd0);
    check32("rst_lo", bus.lo_E, 32'd0);
    chk_en = 1'b1;

    run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m3x5", 2'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_minmin", 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_m7d2", 2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100d7", 2'd2, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_by0", 2'd2, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_min_m1", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div_by0_neg", 2'd3, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_7dm2", 2'd3, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);

    // Flush in RUN cycle 10, with an ignored start in RUN cycle 5.
    @(posedge clk); #1;
    bus.start_E = 1'b1; bus.op_E = 2'd0; bus.srcA_E = 32'd6; bus.srcB_E = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      bus.start_E = (c == 5);
      if (c == 5) begin
        bus.op_E = 2'd1; bus.srcA_E = 32'd3; bus.srcB_E = 32'd3;
      end
      bus.flush_E = (c == 10);
    end
    @(negedge clk);
    check32("flush_stall_k", 32'(bus.multStall_E), 32'd1);
    @(posedge clk); #1;
    bus.flush_E = 1'b0;
    @(negedge clk);
    check32("flush_stall_k1", 32'(bus.multStall_E), 32'd0);

    // Start and flush together in IDLE: request dropped.
    @(posedge clk); #1;
    bus.start_E = 1'b1; bus.flush_E = 1'b1;
    bus.op_E = 2'd0; bus.srcA_E = 32'd5; bus.srcB_E = 32'd5;
    @(negedge clk);
    check32("startflush_stall", 32'(bus.multStall_E), 32'd0);
    @(posedge clk); #1;
    bus.start_E = 1'b0; bus.flush_E = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check32("flush_no_done", 32'(n_done), 32'd0);
    check32("flush_hi_kept", bus.hi_E, 32'h0000_0001);
    check32("flush_lo_kept", bus.lo_E, 32'hFFFF_FFFD);

    // Back-to-back: second start issued in the DONE cycle.
    @(posedge clk); #1;
    bus.start_E = 1'b1; bus.op_E = 2'd0; bus.srcA_E = 32'd6; bus.srcB_E = 32'd7;
    @(posedge clk); #1;
    bus.start_E = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    bus.start_E = 1'b1; bus.op_E = 2'd2; bus.srcA_E = 32'hFFFF_FFFF; bus.srcB_E = 32'd16;
    @(negedge clk);
    check32("b2b_done1", 32'(bus.done), 32'd1);
    check32("b2b_stall1", 32'(bus.multStall_E), 32'd1);
    check32("b2b_lo1", bus.lo_E, 32'd42);
    check32("b2b_hi1", bus.hi_E, 32'd0);
    @(posedge clk); #1;
    bus.start_E = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        lat = i;
      end
    end
    check32("b2b_latency", 32'(lat), 32'd33);
    check32("b2b_hi2", bus.hi_E, 32'h0000_000F);
    check32("b2b_lo2", bus.lo_E, 32'h0FFF_FFFF);

    // Asynchronous reset in the middle of RUN.
    @(posedge clk); #1;
    bus.start_E = 1'b1; bus.op_E = 2'd1; bus.srcA_E = 32'hFFFF_FFFF; bus.srcB_E = 32'd5;
    @(posedge clk); #1;
    bus.start_E = 1'b0;
    repeat (8) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check32("arst_stall", 32'(bus.multStall_E), 32'd0);
    check32("arst_done", 32'(bus.done), 32'd0);
    check32("arst_hi", bus.hi_E, 32'd0);
    check32("arst_lo", bus.lo_E, 32'd0);
    #4 reset = 1'b0;
    run_op("after_rst", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
